fcp_tx_sched: RTL and testbench
===============================

Name: fcp_tx_sched

Overview:
- Sequences the FCP transmit controller and shares it between two requesters: the slave-ping generator and the command-response path.
- Arbitrates pending requests and launches one transaction at a time by driving the controller's level-sensitive tx_en, tx_type and tx_data.
- Holds tx_en until the controller's tx_done, then enforces a minimum idle gap before the next launch.
- A watchdog recovers the scheduler if tx_done never arrives.

Parameters:
- GAP_CYCLES, 8, idle cycles with tx_en low between transactions; legal range 1..255.
- TIMEOUT, 2047, maximum cycles in BUSY before the watchdog aborts; legal range 16..4095.

Ports:
- clk  input  1  single clock
- rstn  input  1  asynchronous active-low reset
- sched_en  input  1  1 allows new grants; 0 blocks new grants, in-flight transaction completes
- ping_req  input  1  ping request; level, held until ping_gnt
- ping_gnt  output  1  one-cycle pulse, ping request accepted
- ping_done  output  1  one-cycle pulse, ping transaction finished
- rsp_req  input  1  response request; level, held until rsp_gnt
- rsp_data  input  16  response payload; stable while rsp_req is high; sampled at grant
- rsp_gnt  output  1  one-cycle pulse, response accepted
- rsp_done  output  1  one-cycle pulse, response transaction finished
- tx_en  output  1  to tx controller; a rising edge starts a transaction
- tx_type  output  1  to tx controller; 0 = ping, 1 = data
- tx_data  output  16  to tx controller; payload
- tx_done  input  1  from tx controller; end-of-transaction pulse
- busy  output  1  state is not IDLE
- timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: all outputs 0; state IDLE; last_owner = PING, so the response wins the first tie.
- States: IDLE, BUSY, GAP.

IDLE:
- Enter BUSY on the next edge if sched_en=1 and any request is pending.
- Owner selection:
  - Only one request pending: that requester is the owner.
  - Both pending: round-robin; owner is the requester that is not last_owner.
- On the entering edge, all registered together:
  - tx_en <= 1.
  - tx_type <= 1 and tx_data <= rsp_data when owner is RSP.
  - tx_type <= 0 and tx_data <= 16'h0000 when owner is PING.
  - The owner's gnt pulses for exactly 1 cycle.
  - last_owner <= owner.
  - The watchdog counter is cleared.
- Grant latency: 1 cycle from a request seen in IDLE to gnt and tx_en rising.
- A request that drops before its grant is simply not served. No error.

BUSY:
- tx_en, tx_type and tx_data are held constant.
- The watchdog counts +1 per cycle.
- tx_done=1: next edge drives tx_en <= 0, the owner's done pulse for 1 cycle, gap counter <= GAP_CYCLES-1, state GAP.
- Watchdog reaching TIMEOUT-1 without tx_done: next edge drives tx_en <= 0, timeout_err for 1 cycle, no done pulse, gap loaded as above, state GAP.
- tx_done and watchdog expiry in the same cycle: tx_done wins; normal completion, no timeout_err.
- Requests arriving during BUSY stay pending; no grant.

GAP:
- tx_en = 0.
- The counter decrements each cycle; at 0 the state returns to IDLE on the next edge.
- tx_en is therefore low for at least GAP_CYCLES cycles, which guarantees the controller sees a fresh rising edge.

Other rules:
- tx_done while in IDLE or GAP is ignored and has no effect on any output.
- sched_en low affects only the IDLE→BUSY transition; BUSY and GAP proceed normally.
- The watchdog counter is 12 bits and saturates; it never wraps.
- Reset asserted mid-transaction: immediate return to reset values, so tx_en drops asynchronously; pending requests are re-arbitrated after reset release.
- tx_data/tx_type change only on grant edges.

Test Plan:
- Single ping: ping_req=1 in IDLE → ping_gnt and tx_en rise 1 cycle later, tx_type=0, tx_data=0000. tx_done pulse → next cycle tx_en=0, ping_done=1, then tx_en stays low 8 cycles before any new grant.
- Single response: rsp_req=1 with rsp_data=16'hA55A → rsp_gnt, tx_type=1, tx_data=A55A, held through BUSY even if rsp_data changes to 1234 after the grant. tx_done → rsp_done=1.
- Contention: ping_req and rsp_req both held high from reset → grants alternate RSP, PING, RSP, PING across four transactions, each separated by ≥8 idle cycles.
- Timeout: rsp granted, tx_done never asserted → tx_en drops exactly 2047 cycles after the grant edge, timeout_err=1 for 1 cycle, rsp_done stays 0. Scheduler returns to IDLE after the gap and grants the next pending ping.
- sched_en gating: sched_en=0 with ping_req=1 → no grant for 100 cycles. Raising sched_en → ping_gnt 1 cycle later. Dropping sched_en during BUSY → transaction still completes with ping_done.
- Reset mid-operation: rstn low during BUSY → tx_en, busy and all pulses go to 0 immediately. After release with rsp_req still high → rsp_gnt 1 cycle later; a spurious tx_done in IDLE produces no done pulse.

Source files
------------

// File: rtl/fcp_tx_sched.sv
// Shares the FCP transmit controller between the ping generator and the response path.
// One transaction at a time, with a watchdog on tx_done and an enforced idle gap between launches.
//
// state | meaning
// IDLE  | waiting for sched_en and a pending request
// BUSY  | tx_en held high, waiting for tx_done or a watchdog expiry
// GAP   | tx_en low, down-counting the minimum idle gap
module fcp_tx_sched #(
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 2047
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sched_en,
  input  logic        ping_req,
  output logic        ping_gnt,
  output logic        ping_done,
  input  logic        rsp_req,
  input  logic [15:0] rsp_data,
  output logic        rsp_gnt,
  output logic        rsp_done,
  output logic        tx_en,
  output logic        tx_type,
  output logic [15:0] tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic        OWN_PING  = 1'b0;
  localparam logic        OWN_RSP   = 1'b1;
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [11:0] WDOG_LAST = 12'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_owner, last_owner_nxt;
  logic [11:0] wdog, wdog_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic        tx_en_nxt, tx_type_nxt;
  logic [15:0] tx_data_nxt;
  logic        ping_gnt_nxt, rsp_gnt_nxt, ping_done_nxt, rsp_done_nxt, timeout_err_nxt;
  logic        sel_rsp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_owner  <= OWN_PING;
      wdog        <= '0;
      gap_cnt     <= '0;
      tx_en       <= 1'b0;
      tx_type     <= 1'b0;
      tx_data     <= '0;
      ping_gnt    <= 1'b0;
      rsp_gnt     <= 1'b0;
      ping_done   <= 1'b0;
      rsp_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      wdog        <= wdog_nxt;
      gap_cnt     <= gap_cnt_nxt;
      tx_en       <= tx_en_nxt;
      tx_type     <= tx_type_nxt;
      tx_data     <= tx_data_nxt;
      ping_gnt    <= ping_gnt_nxt;
      rsp_gnt     <= rsp_gnt_nxt;
      ping_done   <= ping_done_nxt;
      rsp_done    <= rsp_done_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Response wins when alone, or on a tie when ping owned the last slot.
  assign sel_rsp = rsp_req && (!ping_req || (last_owner == OWN_PING));

  always_comb begin
    state_nxt       = state;
    last_owner_nxt  = last_owner;
    wdog_nxt        = wdog;
    gap_cnt_nxt     = gap_cnt;
    tx_en_nxt       = tx_en;
    tx_type_nxt     = tx_type;
    tx_data_nxt     = tx_data;
    ping_gnt_nxt    = 1'b0;
    rsp_gnt_nxt     = 1'b0;
    ping_done_nxt   = 1'b0;
    rsp_done_nxt    = 1'b0;
    timeout_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (sched_en && (ping_req || rsp_req)) begin
          state_nxt      = BUSY;
          tx_en_nxt      = 1'b1;
          wdog_nxt       = '0;
          last_owner_nxt = sel_rsp ? OWN_RSP : OWN_PING;
          if (sel_rsp) begin
            tx_type_nxt = 1'b1;
            tx_data_nxt = rsp_data;
            rsp_gnt_nxt = 1'b1;
          end else begin
            tx_type_nxt  = 1'b0;
            tx_data_nxt  = 16'h0000;
            ping_gnt_nxt = 1'b1;
          end
        end
      end

      // last_owner doubles as the owner of the in-flight transaction.
      BUSY: begin
        if (tx_done) begin
          state_nxt   = GAP;
          tx_en_nxt   = 1'b0;
          gap_cnt_nxt = GAP_LOAD;
          if (last_owner == OWN_RSP) rsp_done_nxt = 1'b1;
          else                       ping_done_nxt = 1'b1;
        end else if (wdog == WDOG_LAST) begin
          state_nxt       = GAP;
          tx_en_nxt       = 1'b0;
          gap_cnt_nxt     = GAP_LOAD;
          timeout_err_nxt = 1'b1;
        end else if (wdog != 12'hFFF) begin
          wdog_nxt = wdog + 12'd1;
        end
      end

      GAP: begin
        tx_en_nxt = 1'b0;
        if (gap_cnt == 8'd0) state_nxt = IDLE;
        else                 gap_cnt_nxt = gap_cnt - 8'd1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fcp_tx_sched.sv
// Directed bench for fcp_tx_sched: ping, response, contention, watchdog, gating and reset.
module tb_fcp_tx_sched;

  localparam int GAP = 8;
  localparam int TO  = 2047;

  logic        clk, rstn, sched_en;
  logic        ping_req, ping_gnt, ping_done;
  logic        rsp_req, rsp_gnt, rsp_done;
  logic [15:0] rsp_data, tx_data;
  logic        tx_en, tx_type, tx_done, busy, timeout_err;

  int checks = 0;
  int failures = 0;

  fcp_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .sched_en(sched_en),
    .ping_req(ping_req), .ping_gnt(ping_gnt), .ping_done(ping_done),
    .rsp_req(rsp_req), .rsp_data(rsp_data), .rsp_gnt(rsp_gnt), .rsp_done(rsp_done),
    .tx_en(tx_en), .tx_type(tx_type), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int  n;
  bit  seen;
  bit  exp_rsp;

  initial begin
    rstn = 1'b0; sched_en = 1'b1; ping_req = 1'b0; rsp_req = 1'b0;
    rsp_data = 16'h0000; tx_done = 1'b0;
    repeat (3) tick();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnts", {ping_gnt, rsp_gnt, ping_done, rsp_done, timeout_err}, 0);
    chk("rst_tx_data", {tx_type, tx_data}, 0);
    rstn = 1'b1;
    tick();

    // single ping
    ping_req = 1'b1;
    tick();
    chk("ping_gnt", ping_gnt, 1);
    chk("ping_tx_en", tx_en, 1);
    chk("ping_tx_type", tx_type, 0);
    chk("ping_tx_data", tx_data, 16'h0000);
    chk("ping_busy", busy, 1);
    ping_req = 1'b0;
    tick();
    chk("ping_gnt_pulse", ping_gnt, 0);
    chk("ping_hold", tx_en, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("ping_done", ping_done, 1);
    chk("ping_done_tx_en", tx_en, 0);
    ping_req = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !ping_gnt; i++) begin
      tick();
      n++;
      if (tx_en && !ping_gnt) seen = 1'b1;
    end
    chk("gap_edges_to_regrant", n, GAP + 1);
    chk("gap_tx_en_low", seen, 0);
    ping_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (GAP) tick();
    chk("ping2_idle", busy, 0);

    // single response, payload captured at grant
    rsp_data = 16'hA55A; rsp_req = 1'b1;
    tick();
    chk("rsp_gnt", rsp_gnt, 1);
    chk("rsp_tx_type", tx_type, 1);
    chk("rsp_tx_data", tx_data, 16'hA55A);
    rsp_req = 1'b0; rsp_data = 16'h1234;
    tick();
    chk("rsp_data_held", tx_data, 16'hA55A);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("rsp_done", rsp_done, 1);
    chk("rsp_no_ping_done", ping_done, 0);
    repeat (GAP) tick();
    chk("rsp_idle", busy, 0);

    // contention from reset: RSP, PING, RSP, PING
    rstn = 1'b0;
    ping_req = 1'b1; rsp_req = 1'b1; rsp_data = 16'hBEEF;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_rsp = (i % 2 == 0);
      chk($sformatf("cont%0d_gnt", i), {rsp_gnt, ping_gnt}, {exp_rsp, !exp_rsp});
      chk($sformatf("cont%0d_type", i), tx_type, exp_rsp);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk($sformatf("cont%0d_done", i), {rsp_done, ping_done}, {exp_rsp, !exp_rsp});
      if (i == 3) begin
        ping_req = 1'b0; rsp_req = 1'b0;
      end
      seen = 1'b0;
      repeat (GAP) begin
        tick();
        if (tx_en) seen = 1'b1;
      end
      chk($sformatf("cont%0d_gap_low", i), seen, 0);
      tick();
    end
    chk("cont_end_idle", busy, 0);

    // watchdog: response granted, tx_done never comes, ping waits
    rsp_data = 16'h0F0F; rsp_req = 1'b1;
    tick();
    chk("to_rsp_gnt", rsp_gnt, 1);
    rsp_req = 1'b0; ping_req = 1'b1;
    seen = 1'b0;
    repeat (TO - 1) begin
      tick();
      if (!tx_en || timeout_err || ping_gnt) seen = 1'b1;
    end
    chk("to_held_until_expiry", seen, 0);
    tick();
    chk("to_tx_en_drop", tx_en, 0);
    chk("to_err", timeout_err, 1);
    chk("to_no_done", rsp_done, 0);
    tick();
    chk("to_err_pulse", timeout_err, 0);
    repeat (GAP - 1) tick();
    chk("to_gap_low", tx_en, 0);
    tick();
    chk("to_next_ping_gnt", ping_gnt, 1);
    chk("to_next_type", tx_type, 0);
    ping_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("to_ping_done", ping_done, 1);
    repeat (GAP) tick();

    // sched_en gating
    sched_en = 1'b0; ping_req = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (ping_gnt || tx_en || busy) seen = 1'b1;
    end
    chk("gate_no_grant", seen, 0);
    sched_en = 1'b1;
    tick();
    chk("gate_ping_gnt", ping_gnt, 1);
    ping_req = 1'b0; sched_en = 1'b0;
    tick();
    chk("gate_busy_continues", tx_en, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("gate_ping_done", ping_done, 1);
    repeat (GAP) tick();
    chk("gate_idle", busy, 0);
    sched_en = 1'b1;

    // asynchronous reset during BUSY
    rsp_data = 16'h5A5A; rsp_req = 1'b1;
    tick();
    chk("rb_rsp_gnt", rsp_gnt, 1);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("rb_tx_en_async", tx_en, 0);
    chk("rb_busy_async", busy, 0);
    chk("rb_pulses_async", {ping_gnt, rsp_gnt, ping_done, rsp_done, timeout_err}, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rb_regrant", rsp_gnt, 1);
    chk("rb_regrant_data", tx_data, 16'h5A5A);
    rsp_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("rb_rsp_done", rsp_done, 1);
    repeat (GAP) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_tx_done_ignored", {ping_done, rsp_done, tx_en, busy, timeout_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
